// File: rtl/sine_pkg.sv
// sine_pkg: meter FSM states and midscale/hysteresis threshold helpers
package sine_pkg;
  typedef enum logic [1:0] {SEEK, ARM, MEASURE} state_t;
  function automatic int mid(input int dw);
    return 1 << (dw - 1);
  endfunction
  function automatic int hi_th(input int dw, input int hyst);
    return mid(dw) + hyst;
  endfunction
  function automatic int lo_th(input int dw, input int hyst);
    return mid(dw) - hyst;
  endfunction
endpackage

// File: rtl/sine_xdet.sv
// sine_xdet: hysteresis polarity tracker producing low-sample and rising-crossing flags
module sine_xdet
  import sine_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int HYST    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  output logic               is_low,
  output logic               rise
);
  localparam int HI = hi_th(D_WIDTH, HYST);
  localparam int LO = lo_th(D_WIDTH, HYST);
  logic pol_q, pol_d, hi, lo;
  always_comb begin
    hi     = int'(din) >= HI;
    lo     = int'(din) < LO;
    pol_d  = en ? (hi ? 1'b1 : lo ? 1'b0 : pol_q) : pol_q;
    is_low = en && lo;
    rise   = en && hi && !pol_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pol_q <= 1'b0;
    else     pol_q <= pol_d;
endmodule

// File: rtl/sine_meter.sv
// sine_meter: measures period and peak-to-peak of each cycle between rising midscale crossings
module sine_meter
  import sine_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int P_WIDTH = 16,
  parameter int HYST    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  output logic [P_WIDTH-1:0] period,
  output logic [D_WIDTH-1:0] p2p,
  output logic               valid,
  output logic               locked,
  output logic               overflow
);
  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [D_WIDTH-1:0] min_q, min_d, max_q, max_d, p2p_q, p2p_d;
  logic               valid_q, valid_d, locked_q, locked_d, ovf_q, ovf_d;
  logic               is_low, rise;
  sine_xdet #(.D_WIDTH(D_WIDTH), .HYST(HYST)) u_xdet (
    .clk(clk), .rst(rst), .en(en), .din(din), .is_low(is_low), .rise(rise)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    max_d    = max_q;
    period_d = period_q;
    p2p_d    = p2p_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    ovf_d    = 1'b0;
    case (state_q)
      SEEK: state_d = is_low ? ARM : SEEK;
      ARM: if (rise) begin
        state_d = MEASURE;
        cnt_d   = P_WIDTH'(1);
        min_d   = din;
        max_d   = din;
      end
      MEASURE: if (rise) begin
        period_d = cnt_q;
        p2p_d    = max_q - min_q;
        valid_d  = 1'b1;
        locked_d = 1'b1;
        cnt_d    = P_WIDTH'(1);
        min_d    = din;
        max_d    = din;
      end else if (en) begin
        // a saturated counter cannot represent this cycle, so drop lock and resync
        if (&cnt_q) begin
          ovf_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = SEEK;
        end else begin
          cnt_d = cnt_q + 1'b1;
          min_d = (din < min_q) ? din : min_q;
          max_d = (din > max_q) ? din : max_q;
        end
      end
      default: state_d = SEEK;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= SEEK;
      cnt_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      period_q <= '0;
      p2p_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      max_q    <= max_d;
      period_q <= period_d;
      p2p_q    <= p2p_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  assign period   = period_q;
  assign p2p      = p2p_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_sine_meter.sv
// tb_sine_meter: directed sine-table and corner-case checks for sine_meter
module tb_sine_meter;
  import sine_pkg::*;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  din;
  logic [15:0] per_a;
  logic [7:0]  p2p_a, per_b, p2p_b;
  logic        val_a, lck_a, ovf_a, val_b, lck_b, ovf_b;
  always #5 clk = ~clk;
  sine_meter #(.D_WIDTH(8), .P_WIDTH(16), .HYST(4)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .period(per_a), .p2p(p2p_a),
    .valid(val_a), .locked(lck_a), .overflow(ovf_a)
  );
  sine_meter #(.D_WIDTH(8), .P_WIDTH(8), .HYST(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .din(din), .period(per_b), .p2p(p2p_b),
    .valid(val_b), .locked(lck_b), .overflow(ovf_b)
  );
  typedef struct {
    int          incr;
    bit          tog;
    int          first;
    int          gap;
    logic [15:0] per;
    logic [7:0]  p2p;
  } vec_t;
  vec_t       vt[3];
  logic [7:0] tab[256];
  int         n_vec = 0, n_bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick(input logic e, input logic [7:0] d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    din = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic run_sine(input int k, input bit rs);
    int ph = 0, n = -1, nv = 0, last = 0, cyc = 0;
    bit e;
    if (rs) do_reset();
    while (nv < 4 && cyc < 3000) begin
      e = !vt[k].tog || !cyc[0];
      tick(e, tab[ph[7:0]]);
      if (e) begin
        ph += vt[k].incr;
        n++;
      end
      if (ovf_a) check($sformatf("v%0d unexpected overflow", k), 32'(ovf_a), 0);
      if (val_a) begin
        if (nv == 0) check($sformatf("v%0d first valid sample", k), n, vt[k].first);
        else         check($sformatf("v%0d valid gap", k), cyc - last, vt[k].gap);
        check($sformatf("v%0d period", k), 32'(per_a), 32'(vt[k].per));
        check($sformatf("v%0d p2p", k), 32'(p2p_a), 32'(vt[k].p2p));
        check($sformatf("v%0d locked", k), 32'(lck_a), 1);
        last = cyc;
        nv++;
      end
      cyc++;
    end
    check($sformatf("v%0d valid count", k), nv, 4);
  endtask
  initial begin
    int  ph, nv, k, ovc, at, idx;
    bit  bad;
    for (int i = 0; i < 256; i++)
      tab[i] = 8'($rtoi(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));
    vt[0] = '{incr: 1, tog: 0, first: 514, gap: 256, per: 16'd256, p2p: 8'd255};
    vt[1] = '{incr: 4, tog: 0, first: 129, gap: 64,  per: 16'd64,  p2p: 8'd255};
    vt[2] = '{incr: 8, tog: 1, first: 65,  gap: 64,  per: 16'd32,  p2p: 8'd255};
    do_reset();
    check("reset period", 32'(per_a), 0);
    check("reset p2p", 32'(p2p_a), 0);
    check("reset valid", 32'(val_a), 0);
    check("reset locked", 32'(lck_a), 0);
    check("reset overflow", 32'(ovf_a), 0);
    for (int i = 0; i < 3; i++) run_sine(i, 1'b1);
    // hysteresis band: one low sample arms, then in-band chatter must never cross
    do_reset();
    tick(1'b1, 8'd100);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, i[0] ? 8'd130 : 8'd126);
      bad |= val_a | lck_a;
    end
    check("hyst valid/locked seen", 32'(bad), 0);
    check("hyst state", 32'(dut.state_q), 32'(ARM));
    // asynchronous reset mid-measurement
    do_reset();
    ph = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1'b1, tab[ph[7:0]]);
      ph += 4;
    end
    check("pre-reset locked", 32'(lck_a), 1);
    #3 rst = 1'b1;
    #1;
    check("async rst period", 32'(per_a), 0);
    check("async rst p2p", 32'(p2p_a), 0);
    check("async rst locked", 32'(lck_a), 0);
    check("async rst state", 32'(dut.state_q), 32'(SEEK));
    @(negedge clk);
    rst = 1'b0;
    run_sine(1, 1'b0);
    // overflow on the narrow-counter instance
    do_reset();
    ph = 0;
    nv = 0;
    for (int i = 0; i < 400 && nv < 2; i++) begin
      tick(1'b1, tab[ph[7:0]]);
      ph += 4;
      if (val_b) nv++;
    end
    check("p8 lock valids", nv, 2);
    check("p8 locked", 32'(lck_b), 1);
    check("p8 period", 32'(per_b), 64);
    ovc = 0;
    at  = 0;
    for (k = 1; k <= 300; k++) begin
      tick(1'b1, 8'd200);
      if (val_b) check("p8 valid during hold", 32'(val_b), 0);
      if (ovf_b) begin
        ovc++;
        if (ovc == 1) at = k;
      end
    end
    check("p8 overflow pulses", ovc, 1);
    check("p8 overflow sample", at, 255);
    check("p8 locked after ovf", 32'(lck_b), 0);
    check("p8 state after ovf", 32'(dut8.state_q), 32'(SEEK));
    check("p8 period held", 32'(per_b), 64);
    check("p8 p2p held", 32'(p2p_b), 255);
    ph  = 0;
    idx = -1;
    for (int i = 0; i < 300 && idx < 0; i++) begin
      tick(1'b1, tab[ph[7:0]]);
      ph += 4;
      if (lck_b) idx = i;
    end
    check("p8 relock sample", idx, 129);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
